// File: rtl/ps2_key_sender.sv
// Device-side PS/2 transmitter: one {ext, break, code} event becomes up to three
// 11-bit frames ([E0] [F0] code), each followed by GAP idle cycles.
module ps2_key_sender #(
   parameter int CLK_DIV = 4,
   parameter int GAP     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   output logic       key_ready,
   input  logic [7:0] key_code,
   input  logic       key_break,
   input  logic       key_ext,
   output logic       ps2_clk,
   output logic       ps2_data,
   output logic       busy
);

   localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREFIX_E0,
      ST_PREFIX_F0,
      ST_CODE,
      ST_GAP
   } state_t;

   state_t         state;
   state_t         last_byte;
   logic [7:0]     code_q;
   logic           brk_q;
   logic           ext_q;
   logic [3:0]     bit_idx;
   logic [PW-1:0]  phase;
   logic           low_half;
   logic [GW-1:0]  gap_cnt;

   function automatic state_t first_byte(input logic ext, input logic brk);
      if (ext)      return ST_PREFIX_E0;
      else if (brk) return ST_PREFIX_F0;
      else          return ST_CODE;
   endfunction

   function automatic state_t byte_after(input state_t s, input logic brk);
      case (s)
         ST_PREFIX_E0: return brk ? ST_PREFIX_F0 : ST_CODE;
         ST_PREFIX_F0: return ST_CODE;
         default:      return ST_IDLE;
      endcase
   endfunction

   function automatic logic [7:0] byte_val(input state_t s, input logic [7:0] code);
      case (s)
         ST_PREFIX_E0: return 8'hE0;
         ST_PREFIX_F0: return 8'hF0;
         default:      return code;
      endcase
   endfunction

   // Frame bit 0 is start, 1..8 carry the byte LSB first, 9 is odd parity, 10 stop.
   function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
      case (idx)
         4'd0:    return 1'b0;
         4'd9:    return ~^b;
         4'd10:   return 1'b1;
         default: return b[3'(idx - 4'd1)];
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         last_byte <= ST_IDLE;
         code_q    <= '0;
         brk_q     <= 1'b0;
         ext_q     <= 1'b0;
         bit_idx   <= '0;
         phase     <= '0;
         low_half  <= 1'b0;
         gap_cnt   <= '0;
         ps2_clk   <= 1'b1;
         ps2_data  <= 1'b1;
         key_ready <= 1'b1;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (key_valid) begin
                  state     <= first_byte(key_ext, key_break);
                  code_q    <= key_code;
                  brk_q     <= key_break;
                  ext_q     <= key_ext;
                  key_ready <= 1'b0;
                  busy      <= 1'b1;
                  bit_idx   <= '0;
                  phase     <= '0;
                  low_half  <= 1'b0;
                  ps2_clk   <= 1'b1;
                  ps2_data  <= 1'b0;
               end
            end

            ST_PREFIX_E0, ST_PREFIX_F0, ST_CODE: begin
               if (phase != PW'(CLK_DIV - 1)) begin
                  phase <= phase + 1'b1;
               end else begin
                  phase <= '0;
                  if (!low_half) begin
                     low_half <= 1'b1;
                     ps2_clk  <= 1'b0;
                  end else if (bit_idx == 4'd10) begin
                     state     <= ST_GAP;
                     last_byte <= state;
                     gap_cnt   <= '0;
                     low_half  <= 1'b0;
                     ps2_clk   <= 1'b1;
                     ps2_data  <= 1'b1;
                  end else begin
                     // Data only moves at the start of a HIGH phase, so it is
                     // settled for a full phase before the host's falling edge.
                     bit_idx  <= bit_idx + 4'd1;
                     low_half <= 1'b0;
                     ps2_clk  <= 1'b1;
                     ps2_data <= frame_bit(byte_val(state, code_q), bit_idx + 4'd1);
                  end
               end
            end

            ST_GAP: begin
               if (gap_cnt != GW'(GAP - 1)) begin
                  gap_cnt <= gap_cnt + 1'b1;
               end else if (byte_after(last_byte, brk_q) == ST_IDLE) begin
                  state     <= ST_IDLE;
                  key_ready <= 1'b1;
                  busy      <= 1'b0;
               end else begin
                  state    <= byte_after(last_byte, brk_q);
                  bit_idx  <= '0;
                  phase    <= '0;
                  low_half <= 1'b0;
                  ps2_clk  <= 1'b1;
                  ps2_data <= 1'b0;
               end
            end

            default: begin
               state     <= ST_IDLE;
               key_ready <= 1'b1;
               busy      <= 1'b0;
               ps2_clk   <= 1'b1;
               ps2_data  <= 1'b1;
            end
         endcase
      end
   end

   logic unused_ok;
   assign unused_ok = ext_q;

endmodule

// File: tb/tb_ps2_key_sender.sv
// Bench for ps2_key_sender: cycle-level waveform model built from frame rules,
// a line decoder that recovers bytes at falling edges, directed and random events.
module tb_ps2_key_sender;
   localparam int CLK_DIV = 4;
   localparam int GAP     = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_valid = 1'b0;
   logic       key_ready;
   logic [7:0] key_code = 8'h00;
   logic       key_break = 1'b0;
   logic       key_ext = 1'b0;
   logic       ps2_clk;
   logic       ps2_data;
   logic       busy;

   ps2_key_sender #(.CLK_DIV(CLK_DIV), .GAP(GAP)) dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready),
      .key_code(key_code), .key_break(key_break), .key_ext(key_ext),
      .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic c; logic d; } ph_t;

   int         checks = 0;
   int         errors = 0;
   ph_t        exp_q[$];
   logic [7:0] exp_bytes[$];
   logic [7:0] rx_log[$];
   logic       par_log[$];
   logic [10:0] rx_bits;
   logic [10:0] last_frame;
   int         rx_n = 0;
   int         n_fall = 0;
   int         ncyc = 0;
   int         acc_cyc = 0;
   int         ready_lat = 0;
   int         stable_cnt = 0;
   logic       prev_clk = 1'b1;
   logic       prev_data = 1'b1;
   logic       prev_ready = 1'b1;
   logic       started = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected line waveform for one event, cycle by cycle, from the frame rules.
   task automatic model_accept(input logic [7:0] code, input logic brk, input logic ext);
      logic [7:0] bl[$];
      logic [7:0] b;
      logic       bt;
      if (ext) bl.push_back(8'hE0);
      if (brk) bl.push_back(8'hF0);
      bl.push_back(code);
      for (int k = 0; k < bl.size(); k++) begin
         b = bl[k];
         exp_bytes.push_back(b);
         for (int i = 0; i < 11; i++) begin
            if (i == 0)      bt = 1'b0;
            else if (i <= 8) bt = b[i-1];
            else if (i == 9) bt = ~^b;
            else             bt = 1'b1;
            for (int j = 0; j < CLK_DIV; j++) exp_q.push_back('{c: 1'b1, d: bt});
            for (int j = 0; j < CLK_DIV; j++) exp_q.push_back('{c: 1'b0, d: bt});
         end
         for (int j = 0; j < GAP; j++) exp_q.push_back('{c: 1'b1, d: 1'b1});
      end
   endtask

   // Runs mid-cycle: compare this cycle, decode the line, then predict the next edge.
   task automatic cycle_eval();
      ph_t        e;
      logic       idle_exp;
      logic [7:0] b;
      ncyc++;
      idle_exp = (exp_q.size() == 0);
      if (idle_exp) e = '{c: 1'b1, d: 1'b1};
      else          e = exp_q.pop_front();
      if (started) begin
         chk("ps2_clk", 32'(ps2_clk), 32'(e.c));
         chk("ps2_data", 32'(ps2_data), 32'(e.d));
         chk("key_ready", 32'(key_ready), 32'(idle_exp));
         chk("busy", 32'(busy), 32'(!idle_exp));
         if (prev_clk && !ps2_clk) begin
            chk("data_stable", 32'(ps2_data == prev_data && stable_cnt >= CLK_DIV), 32'd1);
            n_fall++;
            rx_bits[rx_n] = ps2_data;
            rx_n++;
            if (rx_n == 11) begin
               rx_n = 0;
               b = rx_bits[8:1];
               last_frame = rx_bits;
               chk("frame_start", 32'(rx_bits[0]), 32'd0);
               chk("frame_stop", 32'(rx_bits[10]), 32'd1);
               chk("frame_parity", 32'(^rx_bits[9:1]), 32'd1);
               rx_log.push_back(b);
               par_log.push_back(rx_bits[9]);
               if (exp_bytes.size() > 0) chk("rx_byte", 32'(b), 32'(exp_bytes.pop_front()));
               else chk("rx_unexpected_byte", 32'(b), 32'hFFFF_FFFF);
            end
         end
         if (!prev_ready && key_ready) ready_lat = ncyc - acc_cyc;
      end
      if (ps2_data == prev_data) stable_cnt++;
      else stable_cnt = 1;
      prev_data  = ps2_data;
      prev_clk   = ps2_clk;
      prev_ready = key_ready;
      if (rst) begin
         exp_q.delete();
         exp_bytes.delete();
         rx_n = 0;
      end else if (key_valid && idle_exp) begin
         model_accept(key_code, key_break, key_ext);
         acc_cyc = ncyc;
      end
   endtask

   task automatic step();
      @(negedge clk);
      cycle_eval();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] code, input logic brk, input logic ext);
      int guard;
      key_valid = 1'b1;
      key_code  = code;
      key_break = brk;
      key_ext   = ext;
      guard = 0;
      while (!key_ready && guard < 2000) begin
         step();
         guard++;
      end
      if (guard >= 2000) chk("send_timeout", 32'd0, 32'd1);
      step();
      key_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      step();
      while (!(key_ready && exp_q.size() == 0) && guard < 2000) begin
         step();
         guard++;
      end
      if (guard >= 2000) chk("idle_timeout", 32'd0, 32'd1);
      step();
   endtask

   initial begin
      #400_000_0;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nf0;
      int guard;
      logic [7:0] c;

      rst = 1'b1;
      @(posedge clk);
      #1;
      started = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk("reset_ps2_clk", 32'(ps2_clk), 32'd1);
      chk("reset_ps2_data", 32'(ps2_data), 32'd1);
      chk("reset_key_ready", 32'(key_ready), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      step();

      // Make 0x1C: a single frame
      rx_log.delete(); par_log.delete();
      nf0 = n_fall;
      send(8'h1C, 1'b0, 1'b0);
      wait_idle();
      chk("t1_falls", 32'(n_fall - nf0), 32'd11);
      chk("t1_frame", 32'(last_frame), 32'b100_0011_1000);
      chk("t1_ready_lat", 32'(ready_lat), 32'd97);
      chk("t1_nbytes", 32'(rx_log.size()), 32'd1);

      // Break 0x1C: F0 then 1C
      rx_log.delete(); par_log.delete();
      send(8'h1C, 1'b1, 1'b0);
      wait_idle();
      chk("t2_ready_lat", 32'(ready_lat), 32'd193);
      chk("t2_nbytes", 32'(rx_log.size()), 32'd2);
      if (rx_log.size() == 2) begin
         chk("t2_b0", 32'(rx_log[0]), 32'hF0);
         chk("t2_p0", 32'(par_log[0]), 32'd1);
         chk("t2_b1", 32'(rx_log[1]), 32'h1C);
         chk("t2_p1", 32'(par_log[1]), 32'd0);
      end

      // Extended break 0x75: E0, F0, 75
      rx_log.delete(); par_log.delete();
      send(8'h75, 1'b1, 1'b1);
      wait_idle();
      chk("t3_ready_lat", 32'(ready_lat), 32'd289);
      chk("t3_nbytes", 32'(rx_log.size()), 32'd3);
      if (rx_log.size() == 3) begin
         chk("t3_b0", 32'(rx_log[0]), 32'hE0);
         chk("t3_p0", 32'(par_log[0]), 32'd0);
         chk("t3_b1", 32'(rx_log[1]), 32'hF0);
         chk("t3_b2", 32'(rx_log[2]), 32'h75);
         chk("t3_p2", 32'(par_log[2]), 32'd0);
      end

      // New event held valid while busy: accepted only once ready returns
      rx_log.delete(); par_log.delete();
      send(8'h1C, 1'b0, 1'b0);
      send(8'h32, 1'b0, 1'b0);
      wait_idle();
      chk("t4_nbytes", 32'(rx_log.size()), 32'd2);
      if (rx_log.size() == 2) begin
         chk("t4_b1", 32'(rx_log[1]), 32'h32);
         chk("t4_p1", 32'(par_log[1]), 32'd0);
      end

      // Reset during bit 5 of a frame, then a clean make 0x1C
      rx_log.delete(); par_log.delete();
      send(8'h1C, 1'b0, 1'b0);
      guard = 0;
      while (rx_n != 6 && guard < 500) begin
         step();
         guard++;
      end
      chk("t5_reach_bit5", 32'(rx_n), 32'd6);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t5_ps2_clk", 32'(ps2_clk), 32'd1);
      chk("t5_ps2_data", 32'(ps2_data), 32'd1);
      chk("t5_key_ready", 32'(key_ready), 32'd1);
      chk("t5_busy", 32'(busy), 32'd0);
      send(8'h1C, 1'b0, 1'b0);
      wait_idle();
      chk("t5_nbytes", 32'(rx_log.size()), 32'd1);
      if (rx_log.size() == 1) chk("t5_b0", 32'(rx_log[0]), 32'h1C);

      // Random events, including verbatim 00/E0/F0 codes and back-to-back offers
      for (int n = 0; n < 40; n++) begin
         for (int d = 0; d < int'($urandom_range(0, 5)); d++) step();
         case ($urandom_range(0, 5))
            0:       c = 8'h00;
            1:       c = 8'hE0;
            2:       c = 8'hF0;
            default: c = 8'($urandom);
         endcase
         send(c, 1'($urandom), 1'($urandom));
         if ($urandom_range(0, 2) == 0) wait_idle();
      end
      wait_idle();
      chk("final_bytes_drained", 32'(exp_bytes.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
